// File: rtl/game_sequencer_pkg.sv
// Shared types and constants for the game-flow sequencer and its frame timer.
package game_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    PLAY       = 3'd2,
    HIT_PAUSE  = 3'd3,
    WAVE_CLEAR = 3'd4,
    OVER       = 3'd5
  } game_state_t;

  localparam int NUM_ALIENS       = 20;
  localparam int START_LIVES      = 3;
  localparam int POINTS_PER_ALIEN = 10;
  localparam int SCORE_W          = 16;
  localparam int BASE_SPEED       = 1;
  localparam int MAX_SPEED        = 4;
  localparam int PAUSE_FRAMES     = 90;
  localparam int CLEAR_FRAMES     = 60;
  localparam int OVER_FRAMES      = 180;
  localparam int TIMER_W          = 8;
  localparam int WAVE_MAX         = 15;
  localparam int AR_W             = $clog2(NUM_ALIENS + 1);

endpackage

// File: rtl/game_sequencer_frame_timer.sv
// Frame down-counter shared by all timed phases. A load value is visible in the
// same cycle it is presented, so an fsync coinciding with the first cycle of a
// phase already counts as one frame of that phase. done fires on the fsync that
// consumes the last frame; a load of 0 or 1 both finish on the first fsync.
module frame_timer
  import game_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               fsync,
  output logic               done
);

  logic [TIMER_W-1:0] cnt;
  logic [TIMER_W-1:0] cur;

  assign cur  = load ? load_val : cnt;
  assign done = fsync && (cur <= TIMER_W'(1));

  // count down one per frame, never below zero
  always_ff @(posedge clk) begin
    if (rst)                         cnt <= '0;
    else if (fsync && (cur != '0))   cnt <= cur - TIMER_W'(1);
    else                             cnt <= cur;
  end

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: sequences attract/start/play/pause/wave-clear/over,
// drives subsystem reset and freeze, and keeps score, lives, wave and speed.
module game_sequencer
  import game_sequencer_pkg::*;
(
  input  logic               pixel_clk,
  input  logic               rst,
  input  logic               fsync,
  input  logic               fire,
  input  logic               alien_hit,
  input  logic               player_hit,
  input  logic [AR_W-1:0]    aliens_remaining,
  output logic               sub_rst,
  output logic               freeze,
  output logic               game_over,
  output logic [2:0]         enemy_speed,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic [3:0]         wave,
  output logic [2:0]         state
);

  game_state_t        st;
  logic               fire_q;
  logic               fire_rise;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_done;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_sat;
  logic               few_left;
  logic [4:0]         spd_raw;
  logic [2:0]         spd_next;

  assign state     = st;
  assign fire_rise = fire && !fire_q;

  // one extra bit catches the carry so the score pins at all-ones
  assign score_sum = {1'b0, score} + (SCORE_W+1)'(POINTS_PER_ALIEN);
  assign score_sat = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

  // 5-bit sum cannot wrap (7 + 15 + 1 max) before clamping to the ceiling
  assign few_left = (aliens_remaining <= AR_W'(NUM_ALIENS / 4));
  assign spd_raw  = 5'(BASE_SPEED) + 5'(wave) + 5'(few_left);
  assign spd_next = (spd_raw > 5'(MAX_SPEED)) ? 3'(MAX_SPEED) : spd_raw[2:0];

  frame_timer u_timer (
    .clk      (pixel_clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .fsync    (fsync),
    .done     (tmr_done)
  );

  // fire edge detector
  always_ff @(posedge pixel_clk) begin
    if (rst) fire_q <= 1'b0;
    else     fire_q <= fire;
  end

  // enemy speed is re-evaluated once per frame, in every phase
  always_ff @(posedge pixel_clk) begin
    if (rst)        enemy_speed <= 3'(BASE_SPEED);
    else if (fsync) enemy_speed <= spd_next;
  end

  // game-flow FSM; timer load is a one-cycle strobe on entry to a timed phase
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      st        <= IDLE;
      sub_rst   <= 1'b1;
      freeze    <= 1'b0;
      game_over <= 1'b0;
      score     <= '0;
      lives     <= 3'(START_LIVES);
      wave      <= '0;
      tmr_load  <= 1'b0;
      tmr_val   <= '0;
    end else begin
      tmr_load <= 1'b0;
      case (st)
        IDLE: begin
          sub_rst <= 1'b1;
          if (fire_rise) begin
            score <= '0;
            lives <= 3'(START_LIVES);
            wave  <= '0;
            st    <= START;
          end
        end
        START: begin
          sub_rst <= 1'b1;
          if (fsync) begin
            sub_rst <= 1'b0;
            st      <= PLAY;
          end
        end
        PLAY: begin
          if (alien_hit) score <= score_sat;
          if (player_hit) begin
            freeze   <= 1'b1;
            tmr_load <= 1'b1;
            if (lives > 3'd1) begin
              lives   <= lives - 3'd1;
              tmr_val <= TIMER_W'(PAUSE_FRAMES);
              st      <= HIT_PAUSE;
            end else begin
              lives     <= 3'd0;
              game_over <= 1'b1;
              tmr_val   <= TIMER_W'(OVER_FRAMES);
              st        <= OVER;
            end
          end else if (fsync && (aliens_remaining == '0)) begin
            freeze   <= 1'b1;
            tmr_load <= 1'b1;
            tmr_val  <= TIMER_W'(CLEAR_FRAMES);
            st       <= WAVE_CLEAR;
          end
        end
        HIT_PAUSE: begin
          if (tmr_done) begin
            freeze <= 1'b0;
            st     <= PLAY;
          end
        end
        WAVE_CLEAR: begin
          if (tmr_done) begin
            freeze  <= 1'b0;
            sub_rst <= 1'b1;
            if (wave != 4'(WAVE_MAX)) wave <= wave + 4'd1;
            st      <= START;
          end
        end
        OVER: begin
          if (tmr_done) begin
            freeze    <= 1'b0;
            game_over <= 1'b0;
            sub_rst   <= 1'b1;
            st        <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench: the driver steps a phase-level reference model every cycle
// and queues the expected outputs; the monitor pops and compares after each edge.
module tb_game_sequencer;
  import game_sequencer_pkg::*;

  localparam int FP = 16;  // frame period in deterministic-fsync mode

  logic               pixel_clk = 1'b0;
  logic               rst, fsync, fire, alien_hit, player_hit;
  logic [AR_W-1:0]    aliens_remaining;
  logic               sub_rst, freeze, game_over;
  logic [2:0]         enemy_speed;
  logic [SCORE_W-1:0] score;
  logic [2:0]         lives;
  logic [3:0]         wave;
  logic [2:0]         state;

  game_sequencer dut (
    .pixel_clk        (pixel_clk),
    .rst              (rst),
    .fsync            (fsync),
    .fire             (fire),
    .alien_hit        (alien_hit),
    .player_hit       (player_hit),
    .aliens_remaining (aliens_remaining),
    .sub_rst          (sub_rst),
    .freeze           (freeze),
    .game_over        (game_over),
    .enemy_speed      (enemy_speed),
    .score            (score),
    .lives            (lives),
    .wave             (wave),
    .state            (state)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct packed {
    logic [2:0]         st;
    logic               sr;
    logic               fz;
    logic               go;
    logic [2:0]         spd;
    logic [SCORE_W-1:0] sc;
    logic [2:0]         lv;
    logic [3:0]         wv;
  } obs_t;

  obs_t sb[$];
  obs_t mon_e, mon_g;
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference model: phase, counters and frames-left, per game rules
  game_state_t m_st = IDLE;
  bit m_sr = 1, m_fz = 0, m_go = 0, m_fire = 0;
  int m_sc = 0, m_lv = START_LIVES, m_wv = 0, m_spd = BASE_SPEED, m_fr = 0;

  int cyc = 0;
  bit rand_fs = 0;
  int frz_fs = 0;
  int ar_nx = 20;

  task automatic model_step();
    bit   rise;
    int   s;
    obs_t e;
    if (rst) begin
      m_st = IDLE; m_sr = 1; m_fz = 0; m_go = 0; m_sc = 0;
      m_lv = START_LIVES; m_wv = 0; m_spd = BASE_SPEED; m_fr = 0; m_fire = 0;
    end else begin
      rise   = fire && !m_fire;
      m_fire = fire;
      if (fsync) begin
        s = BASE_SPEED + m_wv + ((int'(aliens_remaining) <= NUM_ALIENS / 4) ? 1 : 0);
        m_spd = (s > MAX_SPEED) ? MAX_SPEED : s;
      end
      case (m_st)
        IDLE: if (rise) begin
          m_sc = 0; m_lv = START_LIVES; m_wv = 0; m_st = START;
        end
        START: if (fsync) begin
          m_st = PLAY; m_sr = 0;
        end
        PLAY: begin
          if (alien_hit) m_sc = (m_sc + POINTS_PER_ALIEN > 65535) ? 65535 : m_sc + POINTS_PER_ALIEN;
          if (player_hit) begin
            m_fz = 1;
            if (m_lv > 1) begin m_lv--; m_st = HIT_PAUSE; m_fr = PAUSE_FRAMES; end
            else begin m_lv = 0; m_st = OVER; m_go = 1; m_fr = OVER_FRAMES; end
          end else if (fsync && aliens_remaining == 0) begin
            m_fz = 1; m_st = WAVE_CLEAR; m_fr = CLEAR_FRAMES;
          end
        end
        HIT_PAUSE: if (fsync) begin
          m_fr--;
          if (m_fr <= 0) begin m_st = PLAY; m_fz = 0; end
        end
        WAVE_CLEAR: if (fsync) begin
          m_fr--;
          if (m_fr <= 0) begin
            m_st = START; m_fz = 0; m_sr = 1;
            m_wv = (m_wv < 15) ? m_wv + 1 : 15;
          end
        end
        OVER: if (fsync) begin
          m_fr--;
          if (m_fr <= 0) begin m_st = IDLE; m_fz = 0; m_go = 0; m_sr = 1; end
        end
        default: m_st = IDLE;
      endcase
    end
    e.st = m_st; e.sr = m_sr; e.fz = m_fz; e.go = m_go; e.spd = 3'(m_spd);
    e.sc = SCORE_W'(m_sc); e.lv = 3'(m_lv); e.wv = 4'(m_wv);
    sb.push_back(e);
  endtask

  // monitor: one expected entry per clock edge once stimulus has started
  always @(posedge pixel_clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      mon_g.st = state; mon_g.sr = sub_rst; mon_g.fz = freeze; mon_g.go = game_over;
      mon_g.spd = enemy_speed; mon_g.sc = score; mon_g.lv = lives; mon_g.wv = wave;
      n_tests++;
      if (mon_g !== mon_e) begin
        n_fail++;
        $display("FAIL out_cmp t=%0t got st=%0d sr=%0b fz=%0b go=%0b spd=%0d sc=%0d lv=%0d wv=%0d exp st=%0d sr=%0b fz=%0b go=%0b spd=%0d sc=%0d lv=%0d wv=%0d",
                 $time, mon_g.st, mon_g.sr, mon_g.fz, mon_g.go, mon_g.spd, mon_g.sc, mon_g.lv, mon_g.wv,
                 mon_e.st, mon_e.sr, mon_e.fz, mon_e.go, mon_e.spd, mon_e.sc, mon_e.lv, mon_e.wv);
      end
    end
  end

  task automatic chk(string nm, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic tick(bit f, bit ah, bit ph, bit r = 1'b0);
    @(negedge pixel_clk);
    cyc++;
    rst = r; fire = f; alien_hit = ah; player_hit = ph;
    aliens_remaining = AR_W'(ar_nx);
    fsync = rand_fs ? ($urandom_range(0, 7) == 0) : ((cyc % FP) == 0);
    if (fsync && freeze && !r) frz_fs++;
    model_step();
  endtask

  task automatic run_until(game_state_t s, int maxc, string nm);
    int k;
    k = 0;
    while (m_st != s && k < maxc) begin
      tick(0, 0, 0);
      k++;
    end
    if (m_st != s) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout after %0d cycles", nm, maxc);
    end
  endtask

  task automatic settle();
    @(posedge pixel_clk);
    #2;
  endtask

  initial begin
    rst = 1; fire = 0; alien_hit = 0; player_hit = 0; fsync = 0;
    aliens_remaining = AR_W'(20);

    repeat (3) tick(0, 0, 0, 1);
    settle();
    chk("rst_state", state, IDLE);
    chk("rst_sub_rst", sub_rst, 1);
    chk("rst_lives", lives, 3);
    chk("rst_speed", enemy_speed, 1);

    // fire at cycle 10, START holds sub_rst until the frame boundary
    while (cyc < 9) tick(0, 0, 0);
    tick(1, 0, 0);
    settle();
    chk("start_state", state, START);
    chk("start_sub_rst", sub_rst, 1);
    run_until(PLAY, 40, "to_play");
    settle();
    chk("play_state", state, PLAY);
    chk("play_sub_rst", sub_rst, 0);
    chk("play_lives", lives, 3);

    // three kills
    repeat (3) begin tick(0, 1, 0); tick(0, 0, 0); end
    settle();
    chk("score_30", score, 30);

    // player hit: frozen for exactly PAUSE_FRAMES frames
    frz_fs = 0;
    tick(0, 0, 1);
    run_until(PLAY, PAUSE_FRAMES * FP + 40, "pause_exit");
    settle();
    chk("pause_fsyncs", frz_fs, PAUSE_FRAMES);
    chk("pause_lives", lives, 2);

    // wave clear only at a frame boundary
    while (cyc % FP != 5) tick(0, 0, 0);
    ar_nx = 0;
    repeat (5) tick(0, 0, 0);
    settle();
    chk("no_early_clear", state, PLAY);
    run_until(WAVE_CLEAR, 40, "to_clear");
    ar_nx = 20;
    run_until(START, CLEAR_FRAMES * FP + 40, "clear_exit");
    settle();
    chk("clear_wave", wave, 1);
    chk("clear_sub_rst", sub_rst, 1);
    run_until(PLAY, 40, "replay");
    settle();
    chk("speed_wave1", enemy_speed, 2);

    // kill + player hit on the wave-clear fsync: hit wins, score still counts
    while ((cyc + 1) % FP != 0) tick(0, 0, 0);
    ar_nx = 0;
    tick(0, 1, 1);
    settle();
    chk("same_state", state, HIT_PAUSE);
    chk("same_lives", lives, 1);
    chk("same_score", score, 40);
    ar_nx = 20;
    run_until(PLAY, PAUSE_FRAMES * FP + 40, "pause2_exit");

    // advance to wave 3
    repeat (2) begin
      ar_nx = 0;
      run_until(WAVE_CLEAR, 40, "to_clear_n");
      ar_nx = 20;
      run_until(START, CLEAR_FRAMES * FP + 40, "clear_n_exit");
      run_until(PLAY, 40, "replay_n");
    end
    ar_nx = 5;
    do tick(0, 0, 0); while (!fsync);
    settle();
    chk("wave3", wave, 3);
    chk("speed_clamp", enemy_speed, MAX_SPEED);

    // score saturation
    ar_nx = 20;
    repeat (6560) tick(0, 1, 0);
    settle();
    chk("score_sat", score, 65535);

    // last life: game over, fire ignored for OVER_FRAMES frames
    frz_fs = 0;
    tick(0, 0, 1);
    settle();
    chk("over_flag", game_over, 1);
    chk("over_lives", lives, 0);
    for (int k = 0; k < OVER_FRAMES * FP + 40 && m_st == OVER; k++) tick((k % 50) == 3, 0, 0);
    settle();
    chk("over_fsyncs", frz_fs, OVER_FRAMES);
    chk("over_to_idle", state, IDLE);
    chk("over_score_held", score, 65535);

    // fresh game, reset in the middle of a pause
    tick(0, 0, 0);
    tick(1, 0, 0);
    run_until(PLAY, 40, "play3");
    settle();
    chk("new_score", score, 0);
    chk("new_wave", wave, 0);
    tick(0, 0, 1);
    repeat (20) tick(0, 0, 0);
    settle();
    chk("pause3", state, HIT_PAUSE);
    tick(0, 0, 0, 1);
    settle();
    chk("mid_rst_state", state, IDLE);
    chk("mid_rst_freeze", freeze, 0);
    chk("mid_rst_lives", lives, 3);
    chk("mid_rst_sub_rst", sub_rst, 1);

    // random phase, random frame timing
    rand_fs = 1;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 63) == 0) ar_nx = $urandom_range(0, 20);
      tick($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 199) == 0, $urandom_range(0, 1999) == 0);
    end
    settle();
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_drain got=%0d exp=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Top-level game-flow controller. It sequences the playfield subsystems (paddle, bullet, alien_group) through the attract, start, play, pause, wave-clear and game-over phases. It generates their shared reset and freeze controls, keeps score, lives and wave number, and schedules enemy speed per frame. It sits in top between the subsystems and gameover/pixel logic, replacing the raw rst || game_over fan-out.

Parameters:
NUM_ALIENS, 20, aliens per wave (NUM_ROWS*NUM_COLS)
START_LIVES, 3, lives loaded at game start (1..7)
POINTS_PER_ALIEN, 10, score added per alien_hit pulse
SCORE_W, 16, score width
BASE_SPEED, 1, enemy speed in wave 0
MAX_SPEED, 4, enemy speed ceiling
PAUSE_FRAMES, 90, frames frozen after player hit
CLEAR_FRAMES, 60, frames frozen after wave clear
OVER_FRAMES, 180, frames game-over shown before return to attract

Ports:
pixel_clk  in  1  pixel clock; sole clock
rst  in  1  synchronous active-high reset
fsync  in  1  one-cycle frame-start pulse
fire  in  1  fire button, already synchronised to pixel_clk
alien_hit  in  1  one-cycle pulse per alien destroyed
player_hit  in  1  one-cycle pulse when the player is struck
aliens_remaining  in  $clog2(NUM_ALIENS+1)  live alien count
sub_rst  out  1  synchronous reset to paddle/bullet/alien_group
freeze  out  1  subsystems hold position when high
game_over  out  1  high in OVER; drives gameover pixel select
enemy_speed  out  3  speed to alien_group
score  out  SCORE_W  current score, saturating
lives  out  3  remaining lives
wave  out  4  wave index, saturating at 15
state  out  3  game_state_t encoding, for debug LEDs

Behaviour:
- Clock and reset: single clock pixel_clk; reset rst is synchronous, active-high. All state is registered; outputs are driven from registers.
- Reset values: state=IDLE, sub_rst=1, freeze=0, game_over=0, score=0, lives=START_LIVES, wave=0, enemy_speed=BASE_SPEED, frame timer=0. rst asserted mid-game aborts to these values on the next edge; pending pulses are dropped.
- fire_rise = fire & ~fire_q (fire_q registered; reset 0). Only fire_rise is used.
- IDLE: sub_rst=1. On fire_rise: score=0, lives=START_LIVES, wave=0; go to START.
- START: sub_rst=1 until the next fsync. On that fsync, the next cycle enters PLAY with sub_rst=0. At least one full cycle of sub_rst is guaranteed even if fsync and entry coincide.
- PLAY:
  - Each alien_hit adds POINTS_PER_ALIEN to score, saturating at 2^SCORE_W-1.
  - player_hit with lives>1: lives-1, go to HIT_PAUSE.
  - player_hit with lives==1: lives=0, go to OVER.
  - Wave-clear check is sampled only on fsync: aliens_remaining==0 goes to WAVE_CLEAR.
  - Same cycle alien_hit and player_hit: score is updated AND the hit transition is taken.
  - player_hit has priority over wave clear.
- HIT_PAUSE: freeze=1; timer loaded with PAUSE_FRAMES on entry, decremented on each fsync. At 0, return to PLAY (no subsystem reset).
- WAVE_CLEAR: freeze=1; timer=CLEAR_FRAMES. At expiry, wave+1 (saturate 15), go to START.
- OVER: game_over=1, freeze=1; timer=OVER_FRAMES. fire_rise is ignored until expiry; then go to IDLE (score held for display until the next fire_rise).
- alien_hit and player_hit outside PLAY are ignored.
- enemy_speed is updated only on fsync:
  - min(MAX_SPEED, BASE_SPEED + wave + (aliens_remaining <= NUM_ALIENS/4 ? 1 : 0)).
  - Computed at 5-bit width before the clamp, so it cannot wrap.
- Timer is 8 bits. A load of 0 expires on the first fsync.
- Latency: input pulse to output register change is 1 cycle; frame-timed transitions complete 1 cycle after the qualifying fsync.

Decomposition:
- params package gains:
  - typedef enum logic [2:0] game_state_t {IDLE, START, PLAY, HIT_PAUSE, WAVE_CLEAR, OVER}
  - START_LIVES, POINTS_PER_ALIEN, PAUSE_FRAMES, CLEAR_FRAMES, OVER_FRAMES, MAX_SPEED
  - ENEMY_SPEED, which becomes BASE_SPEED
- One sub-module, frame_timer:
  - Inputs: load, load value, fsync. Output: done.
  - 8-bit down-counter; one instance is shared by all timed states.

Test Plan:
- rst then fire_rise at cycle 10 -> START; sub_rst stays 1 until first fsync, then state=PLAY, sub_rst=0, score=0, lives=3.
- In PLAY, 3 alien_hit pulses -> score=30. With score preloaded 65530, one hit -> score=65535 (saturated).
- player_hit with lives=3 -> lives=2, freeze=1 for exactly 90 fsyncs, then PLAY. Third player_hit -> lives=0, game_over=1; fire_rise ignored for 180 fsyncs, then IDLE.
- aliens_remaining driven to 0 between fsyncs -> no change until next fsync; then WAVE_CLEAR, 60 frames, wave=1, START, sub_rst pulse.
- Same-cycle alien_hit + player_hit, aliens_remaining=0 at fsync, lives=2 -> score+10, lives=1, HIT_PAUSE (not WAVE_CLEAR).
- wave=3, aliens_remaining=5 (NUM_ALIENS=20) -> enemy_speed=4 after next fsync (1+3+1=5 clamped). rst asserted in HIT_PAUSE -> all reset values next cycle.
